// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one fullAdder fed LSB first, with valid/ready on both sides.
// Optional signed-overflow output outOvf is enabled by defining SERIAL_ADDER_OVF_EN.

module fullAdder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inOp1,
    input  logic [WIDTH-1:0] inOp2,
    input  logic             inCi,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outRes,
    output logic             outCo,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             outOvf,
`endif
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_op1;
    logic [WIDTH-1:0] r_op2;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_sum;
    logic             w_co;
    logic [WIDTH-1:0] w_res_next;

    fullAdder u_fa (
        .a  (r_op1[0]),
        .b  (r_op2[0]),
        .ci (r_carry),
        .s  (w_sum),
        .co (w_co)
    );

    // Sum bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
    assign w_res_next = {w_sum, r_res[WIDTH-1:1]};

    // Control FSM, datapath shift registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op1    <= {WIDTH{1'b0}};
            r_op2    <= {WIDTH{1'b0}};
            r_res    <= {WIDTH{1'b0}};
            r_carry  <= 1'b0;
            r_cnt    <= {CW{1'b0}};
            outRes   <= {WIDTH{1'b0}};
            outCo    <= 1'b0;
            outValid <= 1'b0;
            busy     <= 1'b0;
            inReady  <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
            outOvf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (inValid && inReady) begin
                        r_op1   <= inOp1;
                        r_op2   <= inOp2;
                        r_carry <= inCi;
                        r_cnt   <= {CW{1'b0}};
                        r_res   <= {WIDTH{1'b0}};
                        r_state <= ADD;
                        inReady <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ADD: begin
                    r_op1   <= {1'b0, r_op1[WIDTH-1:1]};
                    r_op2   <= {1'b0, r_op2[WIDTH-1:1]};
                    r_res   <= w_res_next;
                    r_carry <= w_co;
                    if (r_cnt == LAST_BIT) begin
                        r_state  <= DONE;
                        busy     <= 1'b0;
                        outValid <= 1'b1;
                        outRes   <= w_res_next;
                        outCo    <= w_co;
`ifdef SERIAL_ADDER_OVF_EN
                        // r_carry is the carry into the MSB on this final step.
                        outOvf   <= r_carry ^ w_co;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (outReady) begin
                        r_state  <= IDLE;
                        outValid <= 1'b0;
                        inReady  <= 1'b1;
                    end else begin
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    outValid <= 1'b0;
                    busy     <= 1'b0;
                    inReady  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed-vector bench for serial_adder_ctrl (WIDTH=8), plus a randomised run against a sum model.

module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         inValid = 1'b0;
    logic         inReady;
    logic [W-1:0] inOp1 = 8'h00;
    logic [W-1:0] inOp2 = 8'h00;
    logic         inCi = 1'b0;
    logic         outValid;
    logic         outReady = 1'b0;
    logic [W-1:0] outRes;
    logic         outCo;
    logic         busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic         outOvf;
`endif

    int n_vec = 0;
    int n_miscompare = 0;
    int n_done = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inValid  (inValid),
        .inReady  (inReady),
        .inOp1    (inOp1),
        .inOp2    (inOp2),
        .inCi     (inCi),
        .outValid (outValid),
        .outReady (outReady),
        .outRes   (outRes),
        .outCo    (outCo),
`ifdef SERIAL_ADDER_OVF_EN
        .outOvf   (outOvf),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!inReady && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_accept", 32'(inReady), 32'd1);
        inValid = 1'b1;
        inOp1 = a;
        inOp2 = b;
        inCi = ci;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inOp1 = ~a;
        inOp2 = ~b;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_result(input logic [W-1:0] er, input logic eco, input logic eovf);
        int lat;
        lat = 0;
        while (!outValid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd8);
        check("out_res", 32'(outRes), 32'(er));
        check("out_co", 32'(outCo), 32'(eco));
        check("busy_in_done", 32'(busy), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("out_ovf", 32'(outOvf), 32'(eovf));
`else
        if (eovf === 1'bx) check("ovf_placeholder", 32'(outCo), 32'(eco));
`endif
        n_done++;
    endtask

    task automatic release_result(input logic [W-1:0] er);
        @(negedge clk);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        check("out_valid_drop", 32'(outValid), 32'd0);
        check("in_ready_back", 32'(inReady), 32'd1);
        check("out_res_kept", 32'(outRes), 32'(er));
    endtask

    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic [W-1:0] er, input logic eco, input logic eovf);
        send(a, b, ci);
        wait_result(er, eco, eovf);
        release_result(er);
    endtask

    initial begin
        logic [W:0] ref_sum;
        logic [W-1:0] ra, rb;
        logic rci, rovf;
        int exp_done;

        #12;
        check("reset_in_ready", 32'(inReady), 32'd1);
        check("reset_out_valid", 32'(outValid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_out_res", 32'(outRes), 32'd0);
        check("reset_out_co", 32'(outCo), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_add(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        do_add(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        do_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        do_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

        // Backpressure: result held while a different pair is offered.
        send(8'hA5, 8'h5A, 1'b0);
        wait_result(8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        inValid = 1'b1;
        inOp1 = 8'h11;
        inOp2 = 8'h22;
        inCi = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(outValid), 32'd1);
            check("bp_out_res", 32'(outRes), 32'hFF);
            check("bp_out_co", 32'(outCo), 32'd0);
            check("bp_in_ready", 32'(inReady), 32'd0);
        end
        @(negedge clk);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        check("bp_idle_after_take", 32'(inReady), 32'd1);
        check("bp_valid_after_take", 32'(outValid), 32'd0);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        check("bp_next_accept", 32'(busy), 32'd1);
        wait_result(8'h33, 1'b0, 1'b0);
        release_result(8'h33);

        // Asynchronous reset three cycles into ADD.
        send(8'hC3, 8'h3C, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(inReady), 32'd1);
        check("mid_rst_out_valid", 32'(outValid), 32'd0);
        check("mid_rst_out_res", 32'(outRes), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("no_stale_valid", 32'(outValid), 32'd0);
        check("no_stale_res", 32'(outRes), 32'd0);
        do_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // Randomised pairs with input gaps and output stalls.
        exp_done = n_done + 200;
        for (int k = 0; k < 200; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rci = 1'($urandom);
            ref_sum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rci};
            rovf = (ra[W-1] == rb[W-1]) && (ref_sum[W-1] != ra[W-1]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(ra, rb, rci);
            wait_result(ref_sum[W-1:0], ref_sum[W], rovf);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            check("rand_hold", 32'(outValid), 32'd1);
            release_result(ref_sum[W-1:0]);
        end
        check("handshake_count", 32'(n_done), 32'(exp_done));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
